// File: rtl/emu_axil_pkg.sv
// Shared encodings for the emulator control AXI4-Lite bridge.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package emu_axil_pkg;

    localparam int CTRL_ADDR_WIDTH = 12;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_EXEC = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_EXEC = 2'd1,
        R_RESP = 2'd2
    } r_state_t;

endpackage

// File: rtl/emu_ctrl_axil_bridge.sv
// AXI4-Lite slave turning host reads/writes into single-cycle ctrl_wen/ctrl_ren strobes.
// Latency: AW+W (or AR) accepted at edge 0 -> strobe in cycle 1 -> bvalid/rvalid in cycle 2.
// Backpressure: one write and one read in flight; ready stays low until the response handshakes.
module emu_ctrl_axil_bridge
    import emu_axil_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32
) (
    input  logic                       host_clk,
    input  logic                       host_rst,
    input  logic                       s_axilite_awvalid,
    output logic                       s_axilite_awready,
    input  logic [AXI_ADDR_WIDTH-1:0]  s_axilite_awaddr,
    input  logic                       s_axilite_wvalid,
    output logic                       s_axilite_wready,
    input  logic [31:0]                s_axilite_wdata,
    input  logic [3:0]                 s_axilite_wstrb,
    output logic                       s_axilite_bvalid,
    input  logic                       s_axilite_bready,
    output logic [1:0]                 s_axilite_bresp,
    input  logic                       s_axilite_arvalid,
    output logic                       s_axilite_arready,
    input  logic [AXI_ADDR_WIDTH-1:0]  s_axilite_araddr,
    output logic                       s_axilite_rvalid,
    input  logic                       s_axilite_rready,
    output logic [31:0]                s_axilite_rdata,
    output logic [1:0]                 s_axilite_rresp,
    output logic                       ctrl_wen,
    output logic [CTRL_ADDR_WIDTH-1:0] ctrl_waddr,
    output logic [31:0]                ctrl_wdata,
    output logic                       ctrl_ren,
    output logic [CTRL_ADDR_WIDTH-1:0] ctrl_raddr,
    input  logic [31:0]                ctrl_rdata
);

    // Write path state
    w_state_t                   r_wstate;
    logic                       r_aw_full;
    logic                       r_w_full;
    logic [CTRL_ADDR_WIDTH-1:0] r_aw_addr;
    logic [31:0]                r_w_data;
    logic [3:0]                 r_w_strb;
    logic                       r_awready;
    logic                       r_wready;
    logic                       r_bvalid;
    logic [1:0]                 r_bresp;
    logic                       r_ctrl_wen;
    logic [CTRL_ADDR_WIDTH-1:0] r_ctrl_waddr;
    logic [31:0]                r_ctrl_wdata;

    // Read path state
    r_state_t                   r_rstate;
    logic                       r_arready;
    logic                       r_rvalid;
    logic [31:0]                r_rdata;
    logic                       r_ctrl_ren;
    logic [CTRL_ADDR_WIDTH-1:0] r_ctrl_raddr;

    logic                       w_aw_acc;
    logic                       w_w_acc;
    logic                       w_ar_acc;
    logic                       w_aw_full_nxt;
    logic                       w_w_full_nxt;
    logic [CTRL_ADDR_WIDTH-1:0] w_awaddr_aligned;
    logic [CTRL_ADDR_WIDTH-1:0] w_araddr_aligned;
    logic [CTRL_ADDR_WIDTH-1:0] w_aw_addr_nxt;
    logic [31:0]                w_w_data_nxt;
    logic [3:0]                 w_w_strb_nxt;
    logic                       w_unused_addr;

    // The target decodes only a 4 KiB word-aligned window; everything else aliases.
    assign w_awaddr_aligned = {s_axilite_awaddr[CTRL_ADDR_WIDTH-1:2], 2'b00};
    assign w_araddr_aligned = {s_axilite_araddr[CTRL_ADDR_WIDTH-1:2], 2'b00};
    assign w_unused_addr    = ^{s_axilite_awaddr[AXI_ADDR_WIDTH-1:CTRL_ADDR_WIDTH], s_axilite_awaddr[1:0],
                                s_axilite_araddr[AXI_ADDR_WIDTH-1:CTRL_ADDR_WIDTH], s_axilite_araddr[1:0]};

    // Ready registers are only ever high in the IDLE states, so acceptance implies IDLE.
    assign w_aw_acc      = s_axilite_awvalid && r_awready;
    assign w_w_acc       = s_axilite_wvalid  && r_wready;
    assign w_ar_acc      = s_axilite_arvalid && r_arready;
    assign w_aw_full_nxt = r_aw_full || w_aw_acc;
    assign w_w_full_nxt  = r_w_full  || w_w_acc;
    assign w_aw_addr_nxt = r_aw_full ? r_aw_addr : w_awaddr_aligned;
    assign w_w_data_nxt  = r_w_full  ? r_w_data  : s_axilite_wdata;
    assign w_w_strb_nxt  = r_w_full  ? r_w_strb  : s_axilite_wstrb;

    // Write FSM: collect AW and W in either order, fire one strobe, then hold the response.
    always_ff @(posedge host_clk) begin
        if (host_rst) begin
            r_wstate     <= W_IDLE;
            r_aw_full    <= 1'b0;
            r_w_full     <= 1'b0;
            r_aw_addr    <= '0;
            r_w_data     <= '0;
            r_w_strb     <= '0;
            r_awready    <= 1'b0;
            r_wready     <= 1'b0;
            r_bvalid     <= 1'b0;
            r_bresp      <= AXI_RESP_OKAY;
            r_ctrl_wen   <= 1'b0;
            r_ctrl_waddr <= '0;
            r_ctrl_wdata <= '0;
        end else begin
            r_ctrl_wen <= 1'b0;
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_acc) begin
                        r_aw_full <= 1'b1;
                        r_aw_addr <= w_awaddr_aligned;
                    end
                    if (w_w_acc) begin
                        r_w_full <= 1'b1;
                        r_w_data <= s_axilite_wdata;
                        r_w_strb <= s_axilite_wstrb;
                    end
                    if (w_aw_full_nxt && w_w_full_nxt) begin
                        r_wstate  <= W_EXEC;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        // Byte-lane writes are not supported by the target: reject rather than merge.
                        if (w_w_strb_nxt == 4'hF) begin
                            r_ctrl_wen   <= 1'b1;
                            r_ctrl_waddr <= w_aw_addr_nxt;
                            r_ctrl_wdata <= w_w_data_nxt;
                            r_bresp      <= AXI_RESP_OKAY;
                        end else begin
                            r_bresp      <= AXI_RESP_SLVERR;
                        end
                    end else begin
                        r_awready <= !w_aw_full_nxt;
                        r_wready  <= !w_w_full_nxt;
                    end
                end
                W_EXEC: begin
                    r_bvalid  <= 1'b1;
                    r_aw_full <= 1'b0;
                    r_w_full  <= 1'b0;
                    r_wstate  <= W_RESP;
                end
                W_RESP: begin
                    if (s_axilite_bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Read FSM: one strobe cycle, capture the combinational read data, hold until rready.
    always_ff @(posedge host_clk) begin
        if (host_rst) begin
            r_rstate     <= R_IDLE;
            r_arready    <= 1'b0;
            r_rvalid     <= 1'b0;
            r_rdata      <= '0;
            r_ctrl_ren   <= 1'b0;
            r_ctrl_raddr <= '0;
        end else begin
            r_ctrl_ren <= 1'b0;
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_acc) begin
                        r_arready    <= 1'b0;
                        r_ctrl_ren   <= 1'b1;
                        r_ctrl_raddr <= w_araddr_aligned;
                        r_rstate     <= R_EXEC;
                    end else begin
                        r_arready    <= 1'b1;
                    end
                end
                R_EXEC: begin
                    // Sampled on the same edge a concurrent write lands, so the old value is returned.
                    r_rdata  <= ctrl_rdata;
                    r_rvalid <= 1'b1;
                    r_rstate <= R_RESP;
                end
                R_RESP: begin
                    if (s_axilite_rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign s_axilite_awready = r_awready;
    assign s_axilite_wready  = r_wready;
    assign s_axilite_bvalid  = r_bvalid;
    assign s_axilite_bresp   = r_bresp;
    assign s_axilite_arready = r_arready;
    assign s_axilite_rvalid  = r_rvalid;
    assign s_axilite_rdata   = r_rdata;
    assign s_axilite_rresp   = AXI_RESP_OKAY;
    assign ctrl_wen          = r_ctrl_wen;
    assign ctrl_waddr        = r_ctrl_waddr;
    assign ctrl_wdata        = r_ctrl_wdata;
    assign ctrl_ren          = r_ctrl_ren;
    assign ctrl_raddr        = r_ctrl_raddr;

endmodule

// File: tb/tb_emu_ctrl_axil_bridge.sv
// Self-checking bench for emu_ctrl_axil_bridge with a register-file model on the ctrl side.
// Latency: checks strobe at cycle 1 and response at cycle 2 after acceptance.
// Backpressure: exercises held bvalid/rvalid with bready/rready low and reset mid-transaction.
module tb_emu_ctrl_axil_bridge;
    import emu_axil_pkg::*;

    logic        host_clk = 1'b0;
    logic        host_rst = 1'b1;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic        bready = 1'b1, rready = 1'b1;
    logic [31:0] awaddr = '0, araddr = '0, wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        ctrl_wen, ctrl_ren;
    logic [11:0] ctrl_waddr, ctrl_raddr;
    logic [31:0] ctrl_wdata, ctrl_rdata;

    always #5 host_clk = ~host_clk;

    emu_ctrl_axil_bridge #(.AXI_ADDR_WIDTH(32)) dut (
        .host_clk(host_clk), .host_rst(host_rst),
        .s_axilite_awvalid(awvalid), .s_axilite_awready(awready), .s_axilite_awaddr(awaddr),
        .s_axilite_wvalid(wvalid), .s_axilite_wready(wready), .s_axilite_wdata(wdata),
        .s_axilite_wstrb(wstrb),
        .s_axilite_bvalid(bvalid), .s_axilite_bready(bready), .s_axilite_bresp(bresp),
        .s_axilite_arvalid(arvalid), .s_axilite_arready(arready), .s_axilite_araddr(araddr),
        .s_axilite_rvalid(rvalid), .s_axilite_rready(rready), .s_axilite_rdata(rdata),
        .s_axilite_rresp(rresp),
        .ctrl_wen(ctrl_wen), .ctrl_waddr(ctrl_waddr), .ctrl_wdata(ctrl_wdata),
        .ctrl_ren(ctrl_ren), .ctrl_raddr(ctrl_raddr), .ctrl_rdata(ctrl_rdata)
    );

    // Target register block: combinational read, write lands just after the clock edge.
    logic [31:0] model_mem [0:4095];
    assign ctrl_rdata = model_mem[ctrl_raddr];

    int checks = 0;
    int errors = 0;

    logic [43:0] exp_w   [$];
    logic [11:0] exp_ren [$];
    logic [1:0]  exp_b   [$];
    logic [31:0] exp_r   [$];

    bit          aw_go, w_go, ar_go, wen_go;
    logic [11:0] wen_addr;
    logic [31:0] wen_data;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;   // write data, or expected read data
        logic [3:0]  strb;
        logic [1:0]  resp;   // expected bresp for writes
    } vec_t;
    vec_t vecs [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s actual=%0h required=none", name, act);
    endtask

    // Observe the current cycle, then advance one clock and retire completed handshakes.
    task automatic tick();
        logic [43:0] ew;
        logic [11:0] er;
        logic [1:0]  eb;
        logic [31:0] ed;
        if (ctrl_wen === 1'b1) begin
            if (exp_w.size() == 0) unexpected("ctrl_wen", 64'({ctrl_waddr, ctrl_wdata}));
            else begin
                ew = exp_w.pop_front();
                check("ctrl_write", 64'({ctrl_waddr, ctrl_wdata}), 64'(ew));
            end
        end
        if (ctrl_ren === 1'b1) begin
            if (exp_ren.size() == 0) unexpected("ctrl_ren", 64'(ctrl_raddr));
            else begin
                er = exp_ren.pop_front();
                check("ctrl_raddr", 64'(ctrl_raddr), 64'(er));
            end
        end
        if (bvalid === 1'b1 && bready === 1'b1) begin
            if (exp_b.size() == 0) unexpected("bvalid", 64'(bresp));
            else begin
                eb = exp_b.pop_front();
                check("bresp", 64'(bresp), 64'(eb));
            end
        end
        if (rvalid === 1'b1 && rready === 1'b1) begin
            if (exp_r.size() == 0) unexpected("rvalid", 64'(rdata));
            else begin
                ed = exp_r.pop_front();
                check("rdata_rresp", 64'({rresp, rdata}), 64'({AXI_RESP_OKAY, ed}));
            end
        end
        aw_go    = (awvalid === 1'b1) && (awready === 1'b1);
        w_go     = (wvalid === 1'b1) && (wready === 1'b1);
        ar_go    = (arvalid === 1'b1) && (arready === 1'b1);
        wen_go   = (ctrl_wen === 1'b1);
        wen_addr = ctrl_waddr;
        wen_data = ctrl_wdata;
        @(posedge host_clk);
        #1;
        if (aw_go) awvalid = 1'b0;
        if (w_go)  wvalid  = 1'b0;
        if (ar_go) arvalid = 1'b0;
        if (wen_go) model_mem[wen_addr] = wen_data;
    endtask

    task automatic issue_aw(input logic [31:0] a);
        awvalid = 1'b1;
        awaddr  = a;
    endtask

    task automatic issue_w(input logic [31:0] d, input logic [3:0] s);
        wvalid = 1'b1;
        wdata  = d;
        wstrb  = s;
    endtask

    task automatic issue_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                               input logic [1:0] resp);
        issue_aw(a);
        issue_w(d, s);
        if (s == 4'hF) exp_w.push_back({a[11:2], 2'b00, d});
        exp_b.push_back(resp);
    endtask

    task automatic issue_read(input logic [31:0] a, input logic [31:0] exp_data, input bit push_resp);
        arvalid = 1'b1;
        araddr  = a;
        exp_ren.push_back({a[11:2], 2'b00});
        if (push_resp) exp_r.push_back(exp_data);
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int n = 0;
        while ((exp_w.size() != 0 || exp_ren.size() != 0 || exp_b.size() != 0 || exp_r.size() != 0 ||
                awvalid === 1'b1 || wvalid === 1'b1 || arvalid === 1'b1) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout actual=%0d_cycles required=<%0d pending_w=%0d ren=%0d b=%0d r=%0d",
                     name, n, budget, exp_w.size(), exp_ren.size(), exp_b.size(), exp_r.size());
            exp_w.delete(); exp_ren.delete(); exp_b.delete(); exp_r.delete();
            awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) model_mem[i] = 32'hA5A5_0000 | i;
        model_mem[12'h008] = 32'hDEAD_BEEF;
        model_mem[12'h00C] = 32'h0000_0001;

        vecs[0]  = '{1'b1, 32'h0000_0004, 32'h0000_0010, 4'hF, AXI_RESP_OKAY};
        vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0000_0010, 4'h0, AXI_RESP_OKAY};
        vecs[2]  = '{1'b1, 32'h0000_0000, 32'h0000_FFFF, 4'h3, AXI_RESP_SLVERR};
        vecs[3]  = '{1'b0, 32'h0000_0000, 32'hA5A5_0000, 4'h0, AXI_RESP_OKAY};
        vecs[4]  = '{1'b1, 32'hFFFF_F020, 32'h1234_5678, 4'hF, AXI_RESP_OKAY};
        vecs[5]  = '{1'b0, 32'h0000_1020, 32'h1234_5678, 4'h0, AXI_RESP_OKAY};
        vecs[6]  = '{1'b1, 32'h0000_0102, 32'hCAFE_F00D, 4'hF, AXI_RESP_OKAY};
        vecs[7]  = '{1'b0, 32'h0000_0103, 32'hCAFE_F00D, 4'h0, AXI_RESP_OKAY};
        vecs[8]  = '{1'b0, 32'h0000_0008, 32'hDEAD_BEEF, 4'h0, AXI_RESP_OKAY};
        vecs[9]  = '{1'b1, 32'h0000_0FFC, 32'h1111_2222, 4'h0, AXI_RESP_SLVERR};
        vecs[10] = '{1'b0, 32'h0000_0FFC, 32'hA5A5_0FFC, 4'h0, AXI_RESP_OKAY};

        // Reset values
        tick();
        check("rst_ctl", 64'({bvalid, rvalid, ctrl_wen, ctrl_ren, awready, wready, arready}), 64'h0);
        check("rst_data", 64'({ctrl_wdata, rdata}), 64'h0);
        check("rst_addr", 64'({ctrl_waddr, ctrl_raddr, bresp, rresp}), 64'h0);
        tick();
        tick();
        host_rst = 1'b0;
        tick();
        check("rst_ready_after", 64'({awready, wready, arready}), 64'h7);

        // AW and W together: strobe in cycle 1, response in cycle 2
        issue_write(32'h004, 32'h10, 4'hF, AXI_RESP_OKAY);
        tick();
        check("s1_wen_cycle1", 64'({ctrl_wen, ctrl_waddr, ctrl_wdata}), 64'({1'b1, 12'h004, 32'h10}));
        check("s1_ready_low", 64'({awready, wready}), 64'h0);
        tick();
        check("s1_bvalid_cycle2", 64'({bvalid, bresp, ctrl_wen}), 64'({1'b1, AXI_RESP_OKAY, 1'b0}));
        run_until_idle("s1", 20);

        // W three cycles ahead of an unaligned AW
        issue_w(32'hABCD_0001, 4'hF);
        tick();
        check("s2_w_taken", 64'({wready, awready, ctrl_wen}), 64'({1'b0, 1'b1, 1'b0}));
        tick();
        check("s2_wait1", 64'({wready, ctrl_wen}), 64'h0);
        tick();
        check("s2_wait2", 64'({wready, ctrl_wen}), 64'h0);
        issue_aw(32'h112);
        exp_w.push_back({12'h110, 32'hABCD_0001});
        exp_b.push_back(AXI_RESP_OKAY);
        tick();
        check("s2_wen_addr", 64'({ctrl_wen, ctrl_waddr}), 64'({1'b1, 12'h110}));
        run_until_idle("s2", 20);

        // Vector table, each transaction run to completion
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].is_wr) issue_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp);
            else               issue_read(vecs[i].addr, vecs[i].data, 1'b1);
            run_until_idle($sformatf("vec%0d", i), 20);
        end

        // Read with rready held low: single strobe, stable held response
        rready = 1'b0;
        issue_read(32'h008, 32'hDEAD_BEEF, 1'b1);
        tick();
        check("s4_ren", 64'({ctrl_ren, ctrl_raddr, arready}), 64'({1'b1, 12'h008, 1'b0}));
        tick();
        check("s4_rvalid", 64'({ctrl_ren, rvalid, rdata}), 64'({1'b0, 1'b1, 32'hDEAD_BEEF}));
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("s4_hold%0d", k), 64'({ctrl_ren, rvalid, arready, rdata}),
                  64'({1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF}));
        end
        rready = 1'b1;
        run_until_idle("s4", 20);
        tick();
        check("s4_done", 64'({rvalid, arready}), 64'({1'b0, 1'b1}));

        // Same-address write and read executing together: read sees the old value
        issue_write(32'h00C, 32'h5, 4'hF, AXI_RESP_OKAY);
        issue_read(32'h00C, 32'h1, 1'b1);
        tick();
        check("s5_same_cycle", 64'({ctrl_wen, ctrl_ren}), 64'h3);
        run_until_idle("s5a", 20);
        issue_read(32'h00C, 32'h5, 1'b1);
        run_until_idle("s5b", 20);

        // Reset with the write in W_RESP and the read in R_EXEC
        bready = 1'b0;
        issue_aw(32'h010);
        issue_w(32'h77, 4'hF);
        exp_w.push_back({12'h010, 32'h77});
        tick();
        issue_read(32'h010, 32'h0, 1'b0);
        tick();
        check("s6_pre_rst", 64'({bvalid, ctrl_ren}), 64'h3);
        host_rst = 1'b1;
        tick();
        check("s6_in_rst", 64'({bvalid, rvalid, ctrl_wen, ctrl_ren, rdata}), 64'h0);
        host_rst = 1'b0;
        bready   = 1'b1;
        tick();
        check("s6_ready_after", 64'({awready, wready, arready}), 64'h7);
        for (int k = 0; k < 4; k++) tick();
        check("s6_drained", 64'(exp_w.size() + exp_ren.size()), 64'h0);
        issue_read(32'h010, 32'h77, 1'b1);
        run_until_idle("s6_read", 20);
        issue_read(32'h00C, 32'h5, 1'b1);
        run_until_idle("s6_read2", 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
